// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the register file and its read ports.
// The state enum covers normal operation and the sweep-clear sequence.
package register_file_pkg;

  localparam int RF_WIDTH_DEFAULT = 16;
  localparam int RF_DEPTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range and zero-register checks, optional write bypass,
// and the output register.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEFAULT,
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [AW-1:0]               read_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic                        write_commit,
  input  logic [AW-1:0]               write_addr,
  input  logic [WIDTH-1:0]            write_word,
  output logic [WIDTH-1:0]            readword
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic             in_range_s;
  logic             zero_hit_s;
  logic [WIDTH-1:0] read_data_s;

  // Select the next read value; out-of-range and the hard-wired zero register read 0
  always_comb begin
    read_data_s = {WIDTH{1'b0}};
    in_range_s  = ({1'b0, read_addr} < DEPTH_W);
    zero_hit_s  = (ZERO_REG != 0) && (read_addr == {AW{1'b0}});
    if (!in_range_s || zero_hit_s) begin
      read_data_s = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && write_commit && (write_addr == read_addr)) begin
      read_data_s = write_word;
    end else begin
      read_data_s = regs[read_addr];
    end
  end

  // Output register giving one cycle of read latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readword <= {WIDTH{1'b0}};
    end else begin
      readword <= read_data_s;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with a one-register-per-cycle sweep clear.
// Storage, write qualification, the IDLE/CLEAR FSM and the sweep counter live here.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEFAULT,
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_word,
  input  logic [AW-1:0]    read_addr_a,
  input  logic [AW-1:0]    read_addr_b,
  output logic [WIDTH-1:0] readword_a,
  output logic [WIDTH-1:0] readword_b,
  input  logic             clear_req,
  output logic             busy
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_e                  state_r;
  logic [AW-1:0]              sweep_r;
  logic [DEPTH-1:0][WIDTH-1:0] regs_r;
  logic                       write_commit_s;

  // A write lands only in IDLE, loses to a same-cycle clear, and skips illegal targets
  always_comb begin
    write_commit_s = 1'b0;
    if ((state_r == IDLE) && enable && !clear_req && ({1'b0, write_addr} < DEPTH_W)) begin
      if ((ZERO_REG != 0) && (write_addr == {AW{1'b0}})) begin
        write_commit_s = 1'b0;
      end else begin
        write_commit_s = 1'b1;
      end
    end else begin
      write_commit_s = 1'b0;
    end
  end

  // FSM, sweep counter and register storage share one block so every register has one driver
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sweep_r <= {AW{1'b0}};
      regs_r  <= {(DEPTH*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (clear_req) begin
            state_r <= CLEAR;
            sweep_r <= {AW{1'b0}};
          end else if (write_commit_s) begin
            regs_r[write_addr] <= write_word;
          end
        end
        CLEAR: begin
          regs_r[sweep_r] <= {WIDTH{1'b0}};
          if (sweep_r == LAST_IDX) begin
            state_r <= IDLE;
            sweep_r <= {AW{1'b0}};
          end else begin
            sweep_r <= sweep_r + AW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          sweep_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  assign busy = (state_r == CLEAR);

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_a (
    .clock(clock), .reset(reset), .read_addr(read_addr_a), .regs(regs_r),
    .write_commit(write_commit_s), .write_addr(write_addr), .write_word(write_word),
    .readword(readword_a)
  );

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_b (
    .clock(clock), .reset(reset), .read_addr(read_addr_b), .regs(regs_r),
    .write_commit(write_commit_s), .write_addr(write_addr), .write_word(write_word),
    .readword(readword_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: default, no-bypass and DEPTH=6 instances share one stimulus stream;
// DEPTH=6 never sees clear_req.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear_req = 1'b0;
  logic [2:0]  write_addr = 3'd0;
  logic [2:0]  read_addr_a = 3'd0;
  logic [2:0]  read_addr_b = 3'd0;
  logic [15:0] write_word = 16'd0;

  logic [15:0] rd_a, rd_b, nb_rd_a, nb_rd_b, s6_rd_a, s6_rd_b;
  logic        busy, nb_busy, s6_busy;

  typedef struct {
    logic [15:0] a, b, nb_a, nb_b, s6_a, s6_b;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem[8];
  logic [15:0] mem6[8];
  logic        m_busy = 1'b0;
  int          m_k = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  register_file dut (
    .clock(clock), .reset(reset), .enable(enable), .write_addr(write_addr),
    .write_word(write_word), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .readword_a(rd_a), .readword_b(rd_b), .clear_req(clear_req), .busy(busy)
  );

  register_file #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .enable(enable), .write_addr(write_addr),
    .write_word(write_word), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .readword_a(nb_rd_a), .readword_b(nb_rd_b), .clear_req(clear_req), .busy(nb_busy)
  );

  register_file #(.DEPTH(6)) dut6 (
    .clock(clock), .reset(reset), .enable(enable), .write_addr(write_addr),
    .write_word(write_word), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .readword_a(s6_rd_a), .readword_b(s6_rd_b), .clear_req(1'b0), .busy(s6_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected registered read for the current inputs (evaluated before the edge)
  function automatic logic [15:0] exp_read(input logic [2:0] addr, input logic byp, input logic is6);
    logic commit;
    if (is6) begin
      if (addr == 3'd0 || addr >= 3'd6) return 16'd0;
      commit = enable && (write_addr != 3'd0) && (write_addr < 3'd6);
      if (byp && commit && addr == write_addr) return write_word;
      return mem6[addr];
    end
    if (addr == 3'd0) return 16'd0;
    commit = enable && !m_busy && !clear_req && (write_addr != 3'd0);
    if (byp && commit && addr == write_addr) return write_word;
    return mem[addr];
  endfunction

  task automatic step(input logic en, input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb, input logic clr);
    exp_t e;
    logic commit8, commit6;
    enable = en; write_addr = wa; write_word = wd;
    read_addr_a = ra; read_addr_b = rb; clear_req = clr;
    e.a    = exp_read(ra, 1'b1, 1'b0);
    e.b    = exp_read(rb, 1'b1, 1'b0);
    e.nb_a = exp_read(ra, 1'b0, 1'b0);
    e.nb_b = exp_read(rb, 1'b0, 1'b0);
    e.s6_a = exp_read(ra, 1'b1, 1'b1);
    e.s6_b = exp_read(rb, 1'b1, 1'b1);
    commit8 = en && !m_busy && !clr && (wa != 3'd0);
    commit6 = en && (wa != 3'd0) && (wa < 3'd6);
    if (m_busy) begin
      mem[m_k] = 16'd0;
      if (m_k == 7) begin m_busy = 1'b0; m_k = 0; end
      else m_k++;
    end else if (clr) begin
      m_busy = 1'b1; m_k = 0;
    end else if (commit8) begin
      mem[wa] = wd;
    end
    if (commit6) mem6[wa] = wd;
    e.busy = m_busy;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("rd_a", rd_a, e.a);
      check_eq("rd_b", rd_b, e.b);
      check_eq("busy", {15'd0, busy}, {15'd0, e.busy});
      check_eq("nb_rd_a", nb_rd_a, e.nb_a);
      check_eq("nb_rd_b", nb_rd_b, e.nb_b);
      check_eq("nb_busy", {15'd0, nb_busy}, {15'd0, e.busy});
      check_eq("s6_rd_a", s6_rd_a, e.s6_a);
      check_eq("s6_rd_b", s6_rd_b, e.s6_b);
      check_eq("s6_busy", {15'd0, s6_busy}, 16'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_a"}, rd_a, 16'd0);
    check_eq({tag, "_rd_b"}, rd_b, 16'd0);
    check_eq({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check_eq({tag, "_nb_rd_a"}, nb_rd_a, 16'd0);
    check_eq({tag, "_nb_busy"}, {15'd0, nb_busy}, 16'd0);
    check_eq({tag, "_s6_rd_a"}, s6_rd_a, 16'd0);
  endtask

  // Assert reset between edges and check the asynchronous clear right away
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'd0;
      mem6[i] = 16'd0;
    end
    m_busy = 1'b0;
    m_k = 0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'd0;
      mem6[i] = 16'd0;
    end
    #12;
    check_all_zero("reset_state");
    #1;
    reset = 1'b1;

    // first write right after release, read one cycle later
    step(1'b1, 3'd3, 16'd20, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd3, 3'd3, 1'b0);
    // same-cycle write/read: bypass vs old value
    step(1'b1, 3'd5, 16'd30, 3'd5, 3'd5, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd5, 3'd3, 1'b0);
    // zero register
    step(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0);
    // address 6 is out of range for the DEPTH=6 instance
    step(1'b1, 3'd6, 16'd7, 3'd6, 3'd6, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd6, 3'd7, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 16'd0, 3'(i), 3'(5 - i), 1'b0);

    // fill, then clear with a colliding write and a second clear mid-sweep
    for (int i = 1; i < 8; i++) step(1'b1, 3'(i), 16'(10 * i), 3'(i - 1), 3'(i), 1'b0);
    step(1'b1, 3'd2, 16'd99, 3'd2, 3'd3, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 3'(i), 16'd99, 3'(i), 3'(7 - i), (i == 3));
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 16'd0, 3'(i), 3'(7 - i), 1'b0);

    // reset in the middle of a sweep
    step(1'b1, 3'd7, 16'd70, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd7, 3'd7, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'd0, 3'd7, 3'd7, 1'b0);
    do_reset();
    step(1'b1, 3'd4, 16'd10, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd4, 3'd4, 1'b0);

    // random traffic with occasional clears
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
